// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the UART transmit stage.
package tt_uart_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;
  // index of the data bit currently on the line
  localparam int BIT_IDX_W  = 3;

endpackage

// File: rtl/tt_sync_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the current head.
module tt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  import tt_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        push_ok, pop_ok;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Requests are masked so an over-full push or empty pop is a no-op
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tt_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames go back-to-back when data waits.
module tt_uart_tx #(
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  import tt_uart_pkg::*;

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0]        DIV_M1  = DW'(DIV - 1);
  localparam logic [DW-1:0]        DIV_ONE = DW'(1);
  localparam logic [BIT_IDX_W-1:0] BIT_ONE = BIT_IDX_W'(1);
  localparam logic [BIT_IDX_W-1:0] BIT_LST = BIT_IDX_W'(7);

  uart_state_e          state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 pop;
  logic                 tick;
  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_head;

  tt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign tick     = (div_q == '0);

  // Frame sequencer; tx_d is the line value for the coming cycle so tx stays registered
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          div_d   = DIV_M1;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          div_d   = DIV_M1;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      ST_DATA: begin
        if (tick) begin
          div_d   = DIV_M1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BIT_ONE;
            tx_d  = shift_q[1];
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      ST_STOP: begin
        if (tick) begin
          // Pending byte starts on this same edge: no idle gap between frames
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            div_d   = DIV_M1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Sequencer state; reset truncates any frame and returns the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Bench for tt_uart_tx: serial decoder plus byte scoreboard, timing and reset checks.
module tb_tt_uart_tx;

  localparam int D4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data4 = '0, in_data2 = '0;
  logic       in_valid4 = 1'b0, in_valid2 = 1'b0;
  logic       in_ready4, in_ready2, tx4, tx2, busy4, busy2;
  logic [2:0] level4, level2;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  logic [7:0] exp4[$];
  int         starts[$];
  int         busy_fall = 0;

  always #5 clk = ~clk;

  tt_uart_tx #(.DIV(D4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .tx(tx4), .busy(busy4), .level(level4)
  );

  tt_uart_tx #(.DIV(2), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .level(level2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a byte until accepted; acc is the cycle just before the accepting edge
  task automatic send4(input logic [7:0] b, output int acc);
    int t;
    t = 0;
    in_valid4 = 1'b1;
    in_data4  = b;
    while (!in_ready4 && t < 300) begin step(); t++; end
    if (!in_ready4) chk("send_timeout", 0, 1);
    exp4.push_back(b);
    acc = ncyc;
    step();
    in_valid4 = 1'b0;
    in_data4  = $urandom_range(0, 255);
  endtask

  task automatic wait_starts(input int n);
    int t;
    t = 0;
    while (starts.size() < n && t < 500) begin step(); t++; end
    if (starts.size() < n) chk("start_timeout", starts.size(), n);
  endtask

  task automatic wait_until(input int c);
    while (ncyc < c) step();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy4 || exp4.size() != 0) && t < 3000) begin step(); t++; end
    chk("drain_idle", int'(busy4), 0);
  endtask

  // Serial monitor: checks every cycle of each frame against the scoreboard head
  initial begin : mon
    logic [9:0] frame;
    logic [7:0] b;
    logic       in_frame, busy_prev;
    int         fstart, pos;
    in_frame  = 1'b0;
    busy_prev = 1'b0;
    frame     = '1;
    fstart    = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx4 == 1'b0) begin
          in_frame = 1'b1;
          fstart   = ncyc;
          starts.push_back(ncyc);
          if (exp4.size() == 0) begin
            chk("spurious_frame", 1, 0);
            frame = '1;
          end else begin
            b     = exp4.pop_front();
            frame = {1'b1, b, 1'b0};
          end
        end
        if (in_frame) begin
          pos = ncyc - fstart;
          chk($sformatf("tx_bit%0d", pos / D4), int'(tx4), int'(frame[pos / D4]));
          if (pos == 10 * D4 - 1) in_frame = 1'b0;
        end
      end
      if (busy_prev && !busy4) busy_fall = ncyc;
      busy_prev = busy4;
    end
  end

  initial begin : main
    int acc[6];
    int s, n0, a2;
    logic [19:0] got20, exp20;
    int seq[10];

    // Reset state while held
    step(); step();
    chk("rst_tx", int'(tx4), 1);
    chk("rst_level", int'(level4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_ready", int'(in_ready4), 1);
    rst = 1'b0;
    step();

    // Reset mid-frame: line must go high and FIFO empty without a clock edge
    send4(8'h00, acc[0]);
    send4(8'h00, acc[1]);
    send4(8'h00, acc[2]);
    repeat (10) step();
    chk("pre_rst_tx", int'(tx4), 0);
    chk("pre_rst_level", int'(level4), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx4), 1);
    chk("async_rst_level", int'(level4), 0);
    chk("async_rst_busy", int'(busy4), 0);
    chk("async_rst_ready", int'(in_ready4), 1);
    exp4.delete();
    step(); step();
    rst = 1'b0;
    step();
    chk("post_rst_tx", int'(tx4), 1);

    // Single byte 0x55: latency and busy duration
    n0 = starts.size();
    send4(8'h55, acc[0]);
    wait_starts(n0 + 1);
    s = starts[n0];
    chk("tx_fall_lat", s - acc[0], 2);
    wait_idle();
    chk("busy_len", busy_fall - s, 40);

    // Back-pressure: six bytes offered continuously into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send4(8'hC0 + 8'(i), acc[i]);
    for (int i = 1; i < 5; i++) chk("bp_consec", acc[i] - acc[i-1], 1);
    chk("bp_ready_low", int'(in_ready4), 0);
    chk("bp_level_full", int'(level4), 4);
    send4(8'hC5, acc[5]);
    chk("bp_6th_accept", acc[5] - acc[0], 42);
    wait_idle();

    // Back-to-back 0x00 then 0xFF: second start bit follows the stop bit directly
    n0 = starts.size();
    send4(8'h00, acc[0]);
    send4(8'hFF, acc[1]);
    wait_starts(n0 + 2);
    chk("b2b_gap", starts[n0+1] - starts[n0], 40);
    wait_idle();

    // Push on the pop edge at level 2, eight times, wrapping the pointers
    n0 = starts.size();
    send4(8'h31, acc[0]);
    send4(8'h32, acc[1]);
    send4(8'h33, acc[2]);
    wait_starts(n0 + 1);
    s = starts[$];
    chk("wrap_level0", int'(level4), 2);
    for (int i = 0; i < 8; i++) begin
      wait_until(s + 39);
      chk("wrap_ready", int'(in_ready4), 1);
      in_valid4 = 1'b1;
      in_data4  = 8'h40 + 8'(i * 17);
      exp4.push_back(in_data4);
      step();
      in_valid4 = 1'b0;
      chk("wrap_level", int'(level4), 2);
      chk("wrap_start", starts[$], s + 40);
      s = starts[$];
    end
    wait_idle();
    chk("sb_empty", exp4.size(), 0);

    // 0xA3 at DIV=2: expected line pattern, two cycles per bit
    seq = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
    for (int i = 0; i < 20; i++) exp20[i] = 1'(seq[i / 2]);
    in_valid2 = 1'b1;
    in_data2  = 8'hA3;
    a2 = ncyc;
    step();
    in_valid2 = 1'b0;
    chk("a3_idle_before", int'(tx2), 1);
    step();
    chk("a3_lat", ncyc - a2, 2);
    for (int i = 0; i < 20; i++) begin
      got20[i] = tx2;
      step();
    end
    chk("a3_seq", int'(got20), int'(exp20));
    chk("a3_idle_after", int'(tx2), 1);
    chk("a3_busy_after", int'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute backstop so the run always ends
  initial begin : guard
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", ncyc, 0);
    $fatal(1, "timeout");
  end

endmodule
